// File: rtl/radar_seq_pkg.sv
// Shared types, widths and helpers for the radar scan sequencer.
package radar_seq_pkg;

    localparam int IDX_W = 11;
    localparam int CH_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Index of the last row pair, ceil(rows/2)-1; callers keep rows below 2^15.
    function automatic logic [15:0] last_pair_idx(input logic [15:0] rows);
        logic [15:0] pairs;
        pairs = (rows + 16'd1) >> 1;
        return pairs - 16'd1;
    endfunction

endpackage

// File: rtl/radar_scan_counter.sv
// Cascaded column / row-pair / channel counter with end-of-range flags.
module radar_scan_counter #(
    parameter int IDX_W = 11,
    parameter int CH_W  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             step,
    input  logic [IDX_W-1:0] cfg_rows,
    input  logic [IDX_W-1:0] cfg_cols,
    input  logic [CH_W-1:0]  cfg_channels,
    output logic [IDX_W-1:0] col,
    output logic [IDX_W-1:0] pair,
    output logic [CH_W-1:0]  ch,
    output logic             last_col,
    output logic             last_pair,
    output logic             last_ch,
    output logic             last_valid_pair1
);
    import radar_seq_pkg::*;

    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] pair_q, pair_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [IDX_W-1:0] last_pair_lim;
    logic [IDX_W-1:0] last_pair1_lim;

    always_comb begin
        last_pair_lim    = IDX_W'(last_pair_idx(16'(cfg_rows)));
        // Lane 1 is real up to row pair floor(rows/2)-1; none when rows == 1.
        last_pair1_lim   = (cfg_rows >> 1) - IDX_W'(1);
        last_col         = (col_q == cfg_cols - IDX_W'(1));
        last_pair        = (pair_q == last_pair_lim);
        last_ch          = (ch_q == cfg_channels - CH_W'(1));
        last_valid_pair1 = (cfg_rows > IDX_W'(1)) && (pair_q == last_pair1_lim);

        col_d  = col_q;
        pair_d = pair_q;
        ch_d   = ch_q;
        if (clear) begin
            col_d  = '0;
            pair_d = '0;
            ch_d   = '0;
        end else if (step) begin
            if (last_col) begin
                col_d = '0;
                if (last_pair) begin
                    pair_d = '0;
                    ch_d   = last_ch ? '0 : ch_q + CH_W'(1);
                end else begin
                    pair_d = pair_q + IDX_W'(1);
                end
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col_q  <= '0;
            pair_q <= '0;
            ch_q   <= '0;
        end else begin
            col_q  <= col_d;
            pair_q <= pair_d;
            ch_q   <= ch_d;
        end
    end

    assign col  = col_q;
    assign pair = pair_q;
    assign ch   = ch_q;

endmodule

// File: rtl/radar_scan_ctrl.sv
// Frame sequencer: walks channel / row pair / column and issues one registered
// beat per accepted handshake to the two-lane pixel datapath.
module radar_scan_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 11,
    parameter int CH_W       = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] cfg_rows,
    input  logic [IDX_W-1:0] cfg_cols,
    input  logic [CH_W-1:0]  cfg_channels,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] row_idx1,
    output logic [IDX_W-1:0] row_idx2,
    output logic [IDX_W-1:0] col_idx1,
    output logic [IDX_W-1:0] col_idx2,
    output logic [CH_W-1:0]  channel_num,
    output logic [1:0]       lane_valid,
    output logic [1:0]       data_start,
    output logic [1:0]       data_end,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [1:0]       dbg_state
);
    import radar_seq_pkg::*;

    // The row-pair helper works on 16-bit values; the datapath width is carried only for consistency.
    if (DATA_WIDTH < 1 || IDX_W > 15) begin : g_param_check
        $error("radar_scan_ctrl: unsupported DATA_WIDTH/IDX_W");
    end

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, every beat output holds.

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [CH_W-1:0]  chans_q, chans_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] row1_q, row1_d, row2_q, row2_d, col_q, col_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [1:0]       lane_q, lane_d, start_q, start_d, end_q, end_d;
    logic             final_q, final_d;
    logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

    logic [IDX_W-1:0] sel_rows, sel_cols;
    logic [CH_W-1:0]  sel_chans;
    logic             cfg_ok, start_ok, hs, advance, load_beat, drop_beat, cnt_clear;
    logic [IDX_W-1:0] c_col, c_pair, nxt_row1, nxt_row2;
    logic [CH_W-1:0]  c_ch;
    logic             c_last_col, c_last_pair, c_last_ch, c_last_pair1, nxt_lane1;

    // The counter always points at the next beat to present, so the beat
    // registers can be loaded from it directly on start or on a handshake.
    radar_scan_counter #(.IDX_W(IDX_W), .CH_W(CH_W)) u_counter (
        .clock            (clock),
        .reset_n          (reset_n),
        .clear            (cnt_clear),
        .step             (load_beat),
        .cfg_rows         (sel_rows),
        .cfg_cols         (sel_cols),
        .cfg_channels     (sel_chans),
        .col              (c_col),
        .pair             (c_pair),
        .ch               (c_ch),
        .last_col         (c_last_col),
        .last_pair        (c_last_pair),
        .last_ch          (c_last_ch),
        .last_valid_pair1 (c_last_pair1)
    );

    always_comb begin
        sel_rows  = (state_q == IDLE) ? cfg_rows     : rows_q;
        sel_cols  = (state_q == IDLE) ? cfg_cols     : cols_q;
        sel_chans = (state_q == IDLE) ? cfg_channels : chans_q;

        cfg_ok    = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_channels != '0);
        start_ok  = (state_q == IDLE) && start && cfg_ok;
        hs        = out_valid_q && out_ready;
        advance   = (state_q == RUN) && hs && !final_q && !abort;
        load_beat = start_ok || advance;
        drop_beat = (state_q == RUN) && (abort || (hs && final_q));
        cnt_clear = !load_beat && ((state_q != RUN) || drop_beat);

        nxt_row1  = c_pair << 1;
        nxt_row2  = nxt_row1 + IDX_W'(1);
        nxt_lane1 = (nxt_row2 < sel_rows);

        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        chans_d   = chans_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d = RUN;
                    rows_d  = cfg_rows;
                    cols_d  = cfg_cols;
                    chans_d = cfg_channels;
                    busy_d  = 1'b1;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (hs && final_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        out_valid_d = out_valid_q;
        row1_d      = row1_q;
        row2_d      = row2_q;
        col_d       = col_q;
        ch_d        = ch_q;
        lane_d      = lane_q;
        start_d     = start_q;
        end_d       = end_q;
        final_d     = final_q;
        if (load_beat) begin
            out_valid_d = 1'b1;
            row1_d      = nxt_row1;
            row2_d      = nxt_row2;
            col_d       = c_col;
            ch_d        = c_ch;
            lane_d      = {nxt_lane1, 1'b1};
            start_d     = ((c_pair == '0) && (c_col == '0)) ? {nxt_lane1, 1'b1} : 2'b00;
            end_d       = {c_last_pair1 & c_last_col, c_last_pair & c_last_col};
            final_d     = c_last_pair & c_last_col & c_last_ch;
        end else if (drop_beat) begin
            out_valid_d = 1'b0;
            row1_d      = '0;
            row2_d      = '0;
            col_d       = '0;
            ch_d        = '0;
            lane_d      = '0;
            start_d     = '0;
            end_d       = '0;
            final_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            chans_q     <= '0;
            out_valid_q <= 1'b0;
            row1_q      <= '0;
            row2_q      <= '0;
            col_q       <= '0;
            ch_q        <= '0;
            lane_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            final_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            chans_q     <= chans_d;
            out_valid_q <= out_valid_d;
            row1_q      <= row1_d;
            row2_q      <= row2_d;
            col_q       <= col_d;
            ch_q        <= ch_d;
            lane_q      <= lane_d;
            start_q     <= start_d;
            end_q       <= end_d;
            final_q     <= final_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign row_idx1    = row1_q;
    assign row_idx2    = row2_q;
    assign col_idx1    = col_q;
    assign col_idx2    = col_q;
    assign channel_num = ch_q;
    assign lane_valid  = lane_q;
    assign data_start  = start_q;
    assign data_end    = end_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_radar_scan_ctrl.sv
// Randomised scoreboard bench for radar_scan_ctrl against a loop-based frame model.
module tb_radar_scan_ctrl;

    localparam int IDX_W = 11;
    localparam int CH_W  = 4;
    localparam int BW    = 4 * IDX_W + CH_W + 6;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [IDX_W-1:0] cfg_rows = '0;
    logic [IDX_W-1:0] cfg_cols = '0;
    logic [CH_W-1:0]  cfg_channels = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [IDX_W-1:0] row_idx1, row_idx2, col_idx1, col_idx2;
    logic [CH_W-1:0]  channel_num;
    logic [1:0]       lane_valid, data_start, data_end;
    logic             busy, done, cfg_err;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int ready_mode = 0;
    int ready_phase = 0;
    bit expect_done_flag = 1'b0;
    bit pending_done = 1'b0;
    logic [BW-1:0] exp_q[$];

    radar_scan_ctrl #(.DATA_WIDTH(16), .IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .cfg_rows     (cfg_rows),
        .cfg_cols     (cfg_cols),
        .cfg_channels (cfg_channels),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .row_idx1     (row_idx1),
        .row_idx2     (row_idx2),
        .col_idx1     (col_idx1),
        .col_idx2     (col_idx2),
        .channel_num  (channel_num),
        .lane_valid   (lane_valid),
        .data_start   (data_start),
        .data_end     (data_end),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the whole frame as nested loops over channel, pair, column.
    function automatic void push_frame(input int rows, input int cols, input int chs);
        int np;
        logic lane1;
        logic [1:0] st, en;
        np = (rows + 1) / 2;
        for (int ch = 0; ch < chs; ch++)
            for (int p = 0; p < np; p++)
                for (int c = 0; c < cols; c++) begin
                    lane1 = (2 * p + 1 < rows);
                    st    = (p == 0 && c == 0) ? {lane1, 1'b1} : 2'b00;
                    en[0] = (p == np - 1) && (c == cols - 1);
                    en[1] = lane1 && (2 * p + 3 >= rows) && (c == cols - 1);
                    exp_q.push_back({IDX_W'(2 * p), IDX_W'(2 * p + 1), IDX_W'(c), IDX_W'(c),
                                     CH_W'(ch), lane1, 1'b1, st, en});
                end
    endfunction

    // out_ready driver: 0 = always high, 1 = pattern 1,0,0, 2 = random ~75% high
    initial forever begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (ready_phase % 3 == 0);
                ready_phase++;
            end
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every handshake, checks holding and done timing.
    initial begin
        logic [BW-1:0] beat, prev_beat, exp_beat;
        bit prev_stall;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clock);
            beat = {row_idx1, row_idx2, col_idx1, col_idx2, channel_num, lane_valid, data_start, data_end};
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_stable", {out_valid, beat}, {1'b1, prev_beat});
                if (pending_done) begin
                    check("done_pulse", {done, out_valid, busy}, 3'b100);
                    if (done) done_seen++;
                    pending_done = 1'b0;
                end else if (done) begin
                    check("unexpected_done", done, 1'b0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", {1'b1, beat}, {1'b0, beat});
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check("beat", beat, exp_beat);
                        if (exp_q.size() == 0 && expect_done_flag) begin
                            pending_done     = 1'b1;
                            expect_done_flag = 1'b0;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_beat  = beat;
            end
        end
    end

    // Driver tasks
    task automatic scramble_cfg();
        cfg_rows     = IDX_W'($urandom_range(1, 2047));
        cfg_cols     = IDX_W'($urandom_range(1, 2047));
        cfg_channels = CH_W'($urandom_range(1, 15));
    endtask

    task automatic start_frame(input int rows, input int cols, input int chs);
        @(posedge clock);
        #1;
        cfg_rows     = IDX_W'(rows);
        cfg_cols     = IDX_W'(cols);
        cfg_channels = CH_W'(chs);
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        scramble_cfg();
        @(negedge clock);
        check("first_beat", {busy, out_valid}, 2'b11);
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || expect_done_flag || pending_done) && n < budget) begin
            @(posedge clock);
            n++;
        end
        check("frame_in_budget", (n >= budget), 1'b0);
        if (n >= budget) begin
            exp_q.delete();
            expect_done_flag = 1'b0;
            pending_done     = 1'b0;
        end
    endtask

    task automatic run_frame(input int rows, input int cols, input int chs, input int mode, input int restart_at);
        int base;
        base        = done_seen;
        ready_mode  = mode;
        ready_phase = 0;
        push_frame(rows, cols, chs);
        expect_done_flag = 1'b1;
        start_frame(rows, cols, chs);
        if (restart_at >= 0) begin
            repeat (restart_at) @(posedge clock);
            #1;
            start = 1'b1;
            scramble_cfg();
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        wait_frame(4000);
        check("done_count", done_seen - base, 1);
        repeat (2) @(posedge clock);
    endtask

    task automatic check_cfg_err(input int rows, input int cols, input int chs);
        @(posedge clock);
        #1;
        cfg_rows     = IDX_W'(rows);
        cfg_cols     = IDX_W'(cols);
        cfg_channels = CH_W'(chs);
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("cfg_err_pulse", {cfg_err, busy, out_valid}, 3'b100);
        @(negedge clock);
        check("cfg_err_after", {cfg_err, busy, out_valid}, 3'b000);
        repeat (3) @(posedge clock);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({out_valid, row_idx1, row_idx2, col_idx1, col_idx2, channel_num,
                    lane_valid, data_start, data_end, busy, done, cfg_err, dbg_state});
    endfunction

    initial begin
        int base;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", all_outputs(), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        run_frame(4, 3, 2, 0, -1);
        run_frame(3, 2, 1, 0, -1);
        run_frame(2, 4, 1, 1, -1);
        run_frame(1, 3, 2, 0, -1);

        // Abort while beat 5 is presented; that beat still transfers.
        base       = done_seen;
        ready_mode = 0;
        repeat (2) @(posedge clock);
        push_frame(4, 3, 2);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        expect_done_flag = 1'b0;
        start_frame(4, 3, 2);
        repeat (5) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        check("abort_idle", {out_valid, busy, done}, 3'b000);
        check("abort_beats_left", exp_q.size(), 0);
        repeat (4) @(posedge clock);
        check("abort_no_done", done_seen - base, 0);
        run_frame(4, 3, 2, 0, -1);

        check_cfg_err(4, 0, 2);
        check_cfg_err(0, 3, 1);
        check_cfg_err(5, 2, 0);

        run_frame(4, 3, 2, 0, 3);

        for (int i = 0; i < 8; i++)
            run_frame($urandom_range(1, 7), $urandom_range(1, 5), $urandom_range(1, 3), 2,
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : -1);

        // Reset in the middle of a scan.
        base       = done_seen;
        ready_mode = 0;
        push_frame(3, 3, 2);
        expect_done_flag = 1'b0;
        start_frame(3, 3, 2);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        check("reset_midscan", all_outputs(), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        check("reset_no_done", done_seen - base, 0);
        run_frame(2, 2, 1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radar_scan_ctrl.md
# radar_scan_ctrl

Sequencer for the radar two-lane pixel datapath. On a start pulse it walks a frame channel by channel, issuing paired row indices, a column index, the channel number, and per-lane start/end markers to the pixel fetch/processing datapath, one beat per accepted handshake. It sits between the host configuration registers and the datapath that produces `pixel_out`. It owns frame-level sequencing only and never touches pixel data.

## Interface
- `DATA_WIDTH`, 16: datapath sample width. Not used internally; kept for parameter consistency with the datapath.
- `IDX_W`, 11: row/column index width.
- `CH_W`, 4: channel number width.
- Clocking: one clock; reset is synchronous and active-low.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to scan a frame. Only honoured in IDLE.
- `abort` in 1: terminates the scan; returns to IDLE next cycle.
- `cfg_rows` in IDX_W: rows per channel, legal range 1..2047.
- `cfg_cols` in IDX_W: columns per row, legal range 1..2047.
- `cfg_channels` in CH_W: channels per frame, legal range 1..15.
- `out_ready` in 1: datapath accepts the current beat.
- `out_valid` out 1: beat outputs are valid.
- `row_idx1` out IDX_W: lane-0 row (even row).
- `row_idx2` out IDX_W: lane-1 row (row_idx1+1).
- `col_idx1`, `col_idx2` out IDX_W: column for each lane; always equal.
- `channel_num` out CH_W: current channel.
- `lane_valid` out 2: bit k means lane k carries a real row.
- `data_start` out 2: bit k marks lane k's first beat of a channel.
- `data_end` out 2: bit k marks lane k's last valid beat of a channel.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on frame completion.
- `cfg_err` out 1: one-cycle pulse when start is rejected for a zero config field.

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN on `start` with all cfg fields nonzero.
  - cfg values are latched on that cycle; later cfg changes have no effect until the next start.
- IDLE with `start` and any cfg field zero: pulse `cfg_err` next cycle and stay in IDLE.
- Scan order: channel is the outer loop (0..cfg_channels-1), row pair P is the middle loop (0..ceil(cfg_rows/2)-1), column is the inner loop (0..cfg_cols-1).
- Per-beat outputs:
  - `row_idx1` = 2P; `row_idx2` = 2P+1.
  - `lane_valid` = {2P+1 < cfg_rows, 1}.
- Markers:
  - `data_start` = {lane_valid[1], 1} on P=0, col=0.
  - `data_end[0]` on the last pair, last column.
  - `data_end[1]` on the last pair whose row 2P+1 is valid, at its last column.
  - With odd cfg_rows, `data_end[1]` therefore fires one pair before `data_end[0]`.
  - With cfg_rows=1, lane 1 never gets a start or end marker.
- Advance: counters step only when `out_valid && out_ready`. The column wraps into the pair, the pair wraps into the channel.
- RUN → DONE on the handshake of the final beat (last channel, last pair, last column). DONE pulses `done` and returns to IDLE.
- `abort` has priority over everything in RUN or DONE: next state is IDLE, `out_valid`=0, no `done`. An in-flight beat handshaken on the abort cycle still counts.
- `start` in RUN or DONE is ignored.
- Total beats = cfg_channels × ceil(cfg_rows/2) × cfg_cols.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; counters 0.
- First beat: `out_valid`=1 the cycle after the accepted `start`. `busy` rises on the same cycle.
- Holding: while `out_valid && !out_ready`, every beat output holds stable.
- Throughput: one beat per cycle with `out_ready` held high.
- `done` asserts the cycle after the final handshake. On that cycle `out_valid`=0 and `busy`=0.
- Back-to-back frames: a `start` on the `done` cycle is ignored; the next start is accepted in IDLE one cycle later.
- Reset mid-scan: all outputs return to 0 on the next edge with no `done` pulse.

## Structure
- Package `radar_seq_pkg` holds the `scan_state_t` enum (IDLE/RUN/DONE), `IDX_W`, `CH_W`, and the helper that computes the last pair index `(rows+1)>>1` minus 1.
- Sub-module `radar_scan_counter`: cascaded column/pair/channel counter with a `step` input. It outputs the current indices plus flags `last_col`, `last_pair`, `last_ch` and `last_valid_pair1`.
- The top level holds the FSM, config latch, marker logic and output registers.

## Test plan
- rows=4, cols=3, ch=2, `out_ready`=1 → 12 consecutive beats.
  - Channel 0 row pairs (0,1) then (2,3); columns 0..2 in each pair.
  - `data_start`=2'b11 at beats 0 and 6; `data_end`=2'b11 at beats 5 and 11.
  - `done` in cycle 13.
- rows=3, cols=2, ch=1 → 4 beats.
  - Beats 2–3 have `lane_valid`=2'b01 and rows (2,3).
  - `data_end`=2'b10 at beat 1 and 2'b01 at beat 3.
- rows=2, cols=4, ch=1 with `out_ready` toggling 1,0,0,1,… → indices hold during the low cycles; exactly 4 beats; `done` one cycle after the 4th handshake.
- Abort at beat 5 of the rows=4/cols=3/ch=2 scan → `out_valid`=0 and `busy`=0 next cycle; no `done`; a new start then runs from channel 0, row 0, column 0.
- Start with cfg_cols=0 → `cfg_err` pulses; `busy` stays 0; no beats.
- Start pulsed again mid-scan, and reset asserted mid-scan → the start is ignored with the beat count unchanged; the reset clears all outputs to 0 in the next cycle.
